// File: rtl/alu_share_ctrl_if.sv
// Bundle of requester, response and ALU-side signals for alu_share_ctrl.
// The controller takes the slave view; the environment takes the master view.
interface alu_share_ctrl_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req1_a, req0_b, req1_b;
    logic [1:0]  req0_bsel, req1_bsel;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [31:0] resp_result;
    logic        resp_branch;
    logic        resp_err;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b;
    logic [1:0]  alu_branch_sel;
    logic [31:0] alu_result;
    logic        alu_branch;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
        input  req0_bsel, req1_bsel, resp0_ready, resp1_ready, alu_result, alu_branch,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_result, resp_branch,
        output resp_err, alu_op, alu_a, alu_b, alu_branch_sel
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
        output req0_bsel, req1_bsel, resp0_ready, resp1_ready, alu_result, alu_branch,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_result, resp_branch,
        input  resp_err, alu_op, alu_a, alu_b, alu_branch_sel
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer time-sharing one combinational ALU between two requesters.
// One operation in flight: IDLE (accept) -> EXEC (one ALU cycle) -> RESP (hold until consumed).
module alu_share_ctrl #(
    parameter int unsigned NUM_OPS = 9
) (
    input logic             clk,
    input logic             rst,
    alu_share_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        owner_q, owner_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [1:0]  bsel_q, bsel_d;
    logic [31:0] result_q, result_d;
    logic        branch_q, branch_d;
    logic        err_q, err_d;

    logic        any_valid, gnt, gnt_legal;
    logic [3:0]  gnt_op;
    logic [31:0] gnt_a, gnt_b;
    logic [1:0]  gnt_bsel;
    logic        rdy0, rdy1, rv0, rv1;

    // Arbitration: payload-blind; ptr only breaks ties.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        gnt       = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
        gnt_op    = gnt ? bus.req1_op   : bus.req0_op;
        gnt_a     = gnt ? bus.req1_a    : bus.req0_a;
        gnt_b     = gnt ? bus.req1_b    : bus.req0_b;
        gnt_bsel  = gnt ? bus.req1_bsel : bus.req0_bsel;
        gnt_legal = 32'(gnt_op) < NUM_OPS;
    end

    // Next-state, operation latch, result capture and handshake outputs.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        bsel_d   = bsel_q;
        result_d = result_q;
        branch_d = branch_q;
        err_d    = err_q;
        rdy0     = 1'b0;
        rdy1     = 1'b0;
        rv0      = 1'b0;
        rv1      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Ready is masked while reset is held so all handshakes read 0 in reset.
                if (any_valid && !rst) begin
                    rdy0    = ~gnt;
                    rdy1    = gnt;
                    owner_d = gnt;
                    if (gnt_legal) begin
                        op_d    = gnt_op;
                        a_d     = gnt_a;
                        b_d     = gnt_b;
                        bsel_d  = gnt_bsel;
                        state_d = StExec;
                    end else begin
                        // Illegal ops never reach the ALU; park its inputs at zero.
                        op_d     = '0;
                        a_d      = '0;
                        b_d      = '0;
                        bsel_d   = '0;
                        result_d = '0;
                        branch_d = 1'b0;
                        err_d    = 1'b1;
                        state_d  = StResp;
                    end
                end
            end
            StExec: begin
                result_d = bus.alu_result;
                branch_d = bus.alu_branch;
                err_d    = 1'b0;
                state_d  = StResp;
            end
            StResp: begin
                rv0 = ~owner_q;
                rv1 = owner_q;
                if (owner_q ? bus.resp1_ready : bus.resp0_ready) begin
                    state_d = StIdle;
                    ptr_d   = ~owner_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; async reset drops any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            bsel_q   <= '0;
            result_q <= '0;
            branch_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            bsel_q   <= bsel_d;
            result_q <= result_d;
            branch_q <= branch_d;
            err_q    <= err_d;
        end
    end

    assign bus.req0_ready     = rdy0;
    assign bus.req1_ready     = rdy1;
    assign bus.resp0_valid    = rv0;
    assign bus.resp1_valid    = rv1;
    assign bus.resp_result    = result_q;
    assign bus.resp_branch    = branch_q;
    assign bus.resp_err       = err_q;
    assign bus.alu_op         = op_q;
    assign bus.alu_a          = a_q;
    assign bus.alu_b          = b_q;
    assign bus.alu_branch_sel = bsel_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU on the alu_* side.
module tb_alu_share_ctrl;

    logic clk;
    logic rst;
    int   nvec;
    int   nmis;

    alu_share_ctrl_if bus ();

    alu_share_ctrl #(.NUM_OPS(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU driven by the controller's alu_* outputs.
    always_comb begin
        case (bus.alu_op)
            4'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
            4'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
            4'd2:    bus.alu_result = bus.alu_a & bus.alu_b;
            4'd3:    bus.alu_result = bus.alu_a | bus.alu_b;
            4'd4:    bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'd5:    bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            4'd6:    bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            4'd7:    bus.alu_result = $signed(bus.alu_a) >>> bus.alu_b[4:0];
            4'd8:    bus.alu_result = bus.alu_b;
            default: bus.alu_result = 32'd0;
        endcase
        case (bus.alu_branch_sel)
            2'd0:    bus.alu_branch = bus.alu_a == bus.alu_b;
            2'd1:    bus.alu_branch = bus.alu_a != bus.alu_b;
            2'd2:    bus.alu_branch = $signed(bus.alu_a) <  $signed(bus.alu_b);
            default: bus.alu_branch = $signed(bus.alu_a) >= $signed(bus.alu_b);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Single-requester transaction from IDLE with both response readies high.
    task automatic run_op(input bit who, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] bsel,
                          input logic [31:0] exp_res, input logic exp_br, input logic exp_err);
        if (who) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_bsel = bsel;
            bus.req1_valid = 1'b1;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_bsel = bsel;
            bus.req0_valid = 1'b1;
        end
        #1;
        chk("grant_ready", who ? bus.req1_ready : bus.req0_ready, 1);
        chk("other_ready", who ? bus.req0_ready : bus.req1_ready, 0);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (!exp_err) begin
            chk("exec_alu_op", 32'(bus.alu_op), 32'(op));
            chk("exec_alu_a", bus.alu_a, a);
            chk("exec_no_resp", 32'(bus.resp0_valid | bus.resp1_valid), 0);
            cyc();
        end else begin
            chk("illegal_alu_op_not_driven", 32'(bus.alu_op != op), 1);
        end
        chk("resp_valid_owner", who ? bus.resp1_valid : bus.resp0_valid, 1);
        chk("resp_valid_other", who ? bus.resp0_valid : bus.resp1_valid, 0);
        chk("resp_result", bus.resp_result, exp_res);
        chk("resp_branch", 32'(bus.resp_branch), 32'(exp_br));
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        chk("resp_no_ready", 32'(bus.req0_ready | bus.req1_ready), 0);
        cyc();
        chk("resp_done", 32'(bus.resp0_valid | bus.resp1_valid), 0);
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_op = '0; bus.req1_op = '0;
        bus.req0_a = '0; bus.req1_a = '0; bus.req0_b = '0; bus.req1_b = '0;
        bus.req0_bsel = '0; bus.req1_bsel = '0;
        bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
        #3;
        chk("rst_req0_ready", 32'(bus.req0_ready), 0);
        chk("rst_resp_valid", 32'(bus.resp0_valid | bus.resp1_valid), 0);
        chk("rst_result", bus.resp_result, 0);
        chk("rst_err_branch", 32'(bus.resp_err | bus.resp_branch), 0);
        chk("rst_alu_op", 32'(bus.alu_op), 0);
        chk("rst_alu_a", bus.alu_a, 0);
        cyc();
        rst = 1'b0;

        // Add from requester 0 alone: 5 + 3.
        run_op(1'b0, 4'd0, 32'd5, 32'd3, 2'd0, 32'd8, 1'b0, 1'b0);

        // Fresh reset, then both valid: ptr = 0 serves req0 first.
        rst = 1'b1; #2; rst = 1'b0;
        bus.req0_op = 4'd1; bus.req0_a = 32'd10; bus.req0_b = 32'd4; bus.req0_bsel = 2'd0;
        bus.req1_op = 4'd4; bus.req1_a = 32'hF0F0_F0F0; bus.req1_b = 32'hFFFF_FFFF;
        bus.req1_bsel = 2'd0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("both_req0_ready", 32'(bus.req0_ready), 1);
        chk("both_req1_ready", 32'(bus.req1_ready), 0);
        cyc();
        bus.req0_valid = 1'b0;
        chk("both_exec_req1_wait", 32'(bus.req1_ready), 0);
        chk("both_exec_op", 32'(bus.alu_op), 1);
        cyc();
        chk("both_resp0_valid", 32'(bus.resp0_valid), 1);
        chk("both_resp0_result", bus.resp_result, 32'd6);
        chk("both_resp0_branch", 32'(bus.resp_branch), 0);
        // req0 comes back with a branch op; ptr now favours req1.
        bus.resp1_ready = 1'b0;
        cyc();
        bus.req0_op = 4'd1; bus.req0_a = 32'd7; bus.req0_b = 32'd7; bus.req0_bsel = 2'd0;
        bus.req0_valid = 1'b1;
        #1;
        chk("alt_req1_ready", 32'(bus.req1_ready), 1);
        chk("alt_req0_blocked", 32'(bus.req0_ready), 0);
        cyc();
        bus.req1_valid = 1'b0;
        chk("xor_exec_op", 32'(bus.alu_op), 4);
        chk("xor_exec_a", bus.alu_a, 32'hF0F0_F0F0);
        cyc();
        // Backpressure on response 1 for five cycles.
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp1_valid", 32'(bus.resp1_valid), 1);
            chk("bp_result", bus.resp_result, 32'h0F0F_0F0F);
            chk("bp_branch", 32'(bus.resp_branch), 0);
            chk("bp_no_ready", 32'(bus.req0_ready | bus.req1_ready), 0);
            chk("bp_resp0_quiet", 32'(bus.resp0_valid), 0);
            if (i < 4) cyc();
        end
        bus.resp1_ready = 1'b1;
        bus.req1_op = 4'd1; bus.req1_a = 32'd7; bus.req1_b = 32'd7; bus.req1_bsel = 2'd1;
        bus.req1_valid = 1'b1;
        cyc();
        chk("bp_release_req0_ready", 32'(bus.req0_ready), 1);
        chk("bp_release_req1_wait", 32'(bus.req1_ready), 0);
        cyc();
        bus.req0_valid = 1'b0;
        chk("beq_exec_op", 32'(bus.alu_op), 1);
        cyc();
        chk("beq_resp0_valid", 32'(bus.resp0_valid), 1);
        chk("beq_result", bus.resp_result, 0);
        chk("beq_branch", 32'(bus.resp_branch), 1);
        cyc();
        chk("bne_req1_ready", 32'(bus.req1_ready), 1);
        cyc();
        bus.req1_valid = 1'b0;
        cyc();
        chk("bne_resp1_valid", 32'(bus.resp1_valid), 1);
        chk("bne_branch", 32'(bus.resp_branch), 0);
        cyc();

        // blt: -1 < 2 signed; result -1 - 2.
        run_op(1'b0, 4'd1, 32'hFFFF_FFFF, 32'd2, 2'd2, 32'hFFFF_FFFD, 1'b1, 1'b0);
        // Illegal op 12: response one cycle after handshake with err set.
        run_op(1'b1, 4'd12, 32'd1, 32'd2, 2'd0, 32'd0, 1'b0, 1'b1);
        // And from req0 leaves ptr = 1 and a nonzero held result.
        run_op(1'b0, 4'd2, 32'hFF00_FF00, 32'h0F0F_0F0F, 2'd1, 32'h0F00_0F00, 1'b1, 1'b0);

        // Reset during EXEC of a req1 op.
        bus.req0_op = 4'd5; bus.req0_a = 32'd1; bus.req0_b = 32'd4; bus.req0_bsel = 2'd0;
        bus.req1_op = 4'd3; bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_bsel = 2'd0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        chk("mid_req1_wins", 32'(bus.req1_ready), 1);
        cyc();
        chk("mid_exec_op", 32'(bus.alu_op), 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.req0_ready | bus.req1_ready), 0);
        chk("mid_rst_valid", 32'(bus.resp0_valid | bus.resp1_valid), 0);
        chk("mid_rst_alu_op", 32'(bus.alu_op), 0);
        chk("mid_rst_alu_a", bus.alu_a, 0);
        chk("mid_rst_result", bus.resp_result, 0);
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_req0_ready", 32'(bus.req0_ready), 1);
        chk("post_rst_req1_ready", 32'(bus.req1_ready), 0);
        chk("post_rst_no_resp1", 32'(bus.resp1_valid), 0);
        cyc();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("post_rst_exec_op", 32'(bus.alu_op), 5);
        chk("post_rst_no_resp1_exec", 32'(bus.resp1_valid), 0);
        cyc();
        chk("post_rst_resp0", 32'(bus.resp0_valid), 1);
        chk("post_rst_result", bus.resp_result, 32'd16);
        chk("post_rst_no_resp1_resp", 32'(bus.resp1_valid), 0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
